mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Load/store sequencer that sits directly upstream of the 8-bit, 256-byte data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake. It breaks 16-bit accesses into two byte accesses on the memory port, drives the memory's address, write-enable, read-enable and write-data, and assembles read bytes into a single response. The memory reads combinationally and writes on the rising clock edge; this block depends on both properties.

## Interface
Parameters:
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- DW, 8, memory word width; request/response data width is 2*DW

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request; high only in IDLE
- req_op  in  2  operation: 00 LB (load byte), 01 SB (store byte), 10 LH (load pair), 11 SH (store pair)
- req_addr  in  ADDR_W  byte address of the low byte
- req_wdata  in  2*DW  store data; SB uses [7:0], SH uses [7:0] for addr and [15:8] for addr+1
- rsp_valid  out  1  one-cycle completion pulse; fires for loads and for stores
- rsp_rdata  out  2*DW  load result; zero-extended for LB; 0 for stores
- mem_addr  out  ADDR_W  to memory addr
- mem_wr_en  out  1  to memory wr_en
- mem_rd_en  out  1  to memory rd_en
- mem_dat_in  out  DW  to memory dat_in
- mem_dat_out  in  DW  from memory dat_out (combinational read)

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch op, addr and wdata, then go to ACC0.
- ACC0:
  - mem_addr = latched addr.
  - Load: mem_rd_en=1; capture mem_dat_out into rdata[7:0] at the clock edge.
  - Store: mem_wr_en=1 and mem_dat_in = wdata[7:0].
  - Byte op → RESP. Pair op → ACC1.
- ACC1:
  - mem_addr = latched addr + 1, truncated to ADDR_W bits (0xFF → 0x00).
  - Load captures rdata[15:8]; store writes wdata[15:8].
  - Next state: RESP.
- RESP:
  - rsp_valid=1 for exactly this cycle; rsp_rdata is valid in the same cycle.
  - Next state: IDLE.
- LB returns {8'h00, byte}. LH returns {mem[addr+1], mem[addr]} (little-endian).
- Stores return rsp_rdata = 0.
- Memory-side outputs are decoded from state and latched registers only, never from request inputs. In IDLE and RESP: mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_dat_in=0.
- Request inputs are ignored outside IDLE. The requester must hold a request until it sees req_ready.
- Captured rdata persists until the next accepted load.
- rdata is cleared to 0 when a store is accepted.

## Timing
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wr_en=0, mem_rd_en=0, mem_dat_in=0.
- Acceptance edge is T0:
  - Byte op: memory access in cycle T0+1; rsp_valid in T0+2; req_ready high again in T0+3.
  - Pair op: accesses in T0+1 and T0+2; rsp_valid in T0+3; req_ready high again in T0+4.
- Throughput: one byte op per 3 cycles; one pair op per 4 cycles.
- The store byte is committed to memory at the clock edge ending each ACC cycle.
- A load in the cycle after a store to the same address returns the new data; the write lands before the next ACC cycle.
- Reset asserted mid-operation:
  - mem_wr_en drops immediately (asynchronously) and the FSM returns to IDLE.
  - If reset lands in ACC1 of an SH, only the low byte is written. There is no rollback and no rsp_valid.
- Memory contents are not touched by reset.

## Structure
- Shared package mem_pkg holds:
  - op enum (OP_LB, OP_SB, OP_LH, OP_SH)
  - state enum (IDLE, ACC0, ACC1, RESP)
  - ADDR_W and DW defaults
- Single module; no sub-module is warranted. The FSM, latch registers and output decode fit in one always_ff plus one always_comb.

## Test plan
- Reset → all outputs at reset values. SB addr=0x10, wdata=0x00A5 → mem_wr_en high for 1 cycle at addr 0x10, dat_in=0xA5; rsp_valid 2 cycles after acceptance, rsp_rdata=0.
- LB addr=0x10 after the above → rsp_rdata=0x00A5, mem_rd_en high for 1 cycle; rsp_valid at T0+2.
- SH addr=0x20, wdata=0xBEEF, then LH addr=0x20 → writes 0xEF@0x20 and 0xBE@0x21; load returns 0xBEEF at T0+3.
- SH addr=0xFF, wdata=0x1234 → 0x34@0xFF and 0x12@0x00 (wrap); LH addr=0xFF returns 0x1234.
- req_valid held high with changing req_op/addr while busy → ignored; exactly one rsp_valid per accepted request; req_ready low from T0+1 through RESP.
- rst_n pulsed low during ACC1 of SH addr=0x40, wdata=0x5566 → mem_wr_en drops immediately; 0x66@0x40 written, 0x41 unchanged; no rsp_valid; req_ready=1 after release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the load/store sequencer.
package mem_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DW_DEF     = 8;

   typedef enum logic [1:0] {
      OP_LB = 2'b00,
      OP_SB = 2'b01,
      OP_LH = 2'b10,
      OP_SH = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC0 = 2'b01,
      ACC1 = 2'b10,
      RESP = 2'b11
   } state_e;

   // Bit 0 of the opcode selects store, bit 1 selects a two-byte access.
   function automatic logic op_is_store(input op_e op);
      return op[0];
   endfunction

   function automatic logic op_is_pair(input op_e op);
      return op[1];
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of a byte-wide memory with combinational read
// and clocked write. A 16-bit access is split into two byte accesses.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | ready for a request; memory port idle
// ACC0  | access to the latched address (low byte)
// ACC1  | access to latched address + 1, wrapping (pair ops only)
// RESP  | one-cycle completion pulse carrying the assembled load data
module mem_access_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DW     = DW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2*DW-1:0]   req_wdata,
   output logic              rsp_valid,
   output logic [2*DW-1:0]   rsp_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic              mem_rd_en,
   output logic [DW-1:0]     mem_dat_in,
   input  logic [DW-1:0]     mem_dat_out
);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [2*DW-1:0]     wdata_q, wdata_d;
   logic [2*DW-1:0]     rdata_q, rdata_d;
   logic [ADDR_W-1:0]   addr_inc;

   // Second byte address; the natural width truncation gives the wrap to 0.
   assign addr_inc  = addr_q + ADDR_W'(1);
   assign rsp_rdata = rdata_q;

   // State and latched request registers; reset drops the memory strobes at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= OP_LB;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Next-state and output decode; memory outputs depend only on registered state.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_addr   = '0;
      mem_wr_en  = 1'b0;
      mem_rd_en  = 1'b0;
      mem_dat_in = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = op_e'(req_op);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (op_is_store(op_e'(req_op))) begin
                  rdata_d = '0;
               end
               state_d = ACC0;
            end
         end
         ACC0: begin
            mem_addr = addr_q;
            if (op_is_store(op_q)) begin
               mem_wr_en  = 1'b1;
               mem_dat_in = wdata_q[DW-1:0];
            end else begin
               mem_rd_en = 1'b1;
               // Clearing the high half here makes LB zero-extended; LH fills it in ACC1.
               rdata_d   = {{DW{1'b0}}, mem_dat_out};
            end
            state_d = op_is_pair(op_q) ? ACC1 : RESP;
         end
         ACC1: begin
            mem_addr = addr_inc;
            if (op_is_store(op_q)) begin
               mem_wr_en  = 1'b1;
               mem_dat_in = wdata_q[2*DW-1:DW];
            end else begin
               mem_rd_en            = 1'b1;
               rdata_d[2*DW-1:DW]   = mem_dat_out;
            end
            state_d = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural byte memory plus a reference image of
// memory updated per request, randomized traffic, and directed corner cases.
module tb_mem_access_ctrl;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic [7:0]  mem_addr;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [7:0]  mem_dat_in;
   logic [7:0]  mem_dat_out;

   logic [7:0]  mem [256];
   logic [7:0]  ref_mem [256];

   int n_checks;
   int n_pass;

   mem_access_ctrl #(.ADDR_W(8), .DW(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_addr    (mem_addr),
      .mem_wr_en   (mem_wr_en),
      .mem_rd_en   (mem_rd_en),
      .mem_dat_in  (mem_dat_in),
      .mem_dat_out (mem_dat_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory: combinational read, write on rising edge.
   assign mem_dat_out = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wr_en) mem[mem_addr] <= mem_dat_in;
   end

   // One request end to end, checked cycle by cycle against the reference image.
   task automatic do_req(input logic [1:0] op, input logic [7:0] addr,
                         input logic [15:0] wd, input bit junk, input string tag);
      logic [15:0] exp_r;
      logic [7:0]  a;
      logic [7:0]  a1;
      int          nacc;
      bit          is_st;
      is_st = op[0];
      nacc  = op[1] ? 2 : 1;
      a1    = addr + 8'd1;
      case (op)
         2'b00:   exp_r = {8'h00, ref_mem[addr]};
         2'b10:   exp_r = {ref_mem[a1], ref_mem[addr]};
         default: exp_r = 16'h0000;
      endcase

      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s ready_before_accept got=%b exp=1", tag, req_ready);
      else n_pass++;

      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      @(posedge clk); #1;

      for (int k = 0; k < nacc; k++) begin
         a = addr + 8'(k);
         if (junk) begin
            req_valid = 1'b1;
            req_op    = 2'($urandom);
            req_addr  = 8'($urandom);
            req_wdata = 16'($urandom);
         end else begin
            req_valid = 1'b0;
         end
         n_checks++;
         if (req_ready !== 1'b0) $display("FAIL %s ready_busy acc%0d got=%b exp=0", tag, k, req_ready);
         else n_pass++;
         n_checks++;
         if (rsp_valid !== 1'b0) $display("FAIL %s rsp_early acc%0d got=%b exp=0", tag, k, rsp_valid);
         else n_pass++;
         n_checks++;
         if (mem_addr !== a) $display("FAIL %s mem_addr acc%0d got=%h exp=%h", tag, k, mem_addr, a);
         else n_pass++;
         n_checks++;
         if (mem_wr_en !== is_st) $display("FAIL %s wr_en acc%0d got=%b exp=%b", tag, k, mem_wr_en, is_st);
         else n_pass++;
         n_checks++;
         if (mem_rd_en !== !is_st) $display("FAIL %s rd_en acc%0d got=%b exp=%b", tag, k, mem_rd_en, !is_st);
         else n_pass++;
         if (is_st) begin
            n_checks++;
            if (mem_dat_in !== wd[8*k +: 8])
               $display("FAIL %s dat_in acc%0d got=%h exp=%h", tag, k, mem_dat_in, wd[8*k +: 8]);
            else n_pass++;
         end
         @(posedge clk); #1;
         if (is_st) begin
            n_checks++;
            if (mem[a] !== wd[8*k +: 8])
               $display("FAIL %s mem_commit @%h got=%h exp=%h", tag, a, mem[a], wd[8*k +: 8]);
            else n_pass++;
         end
      end

      n_checks++;
      if (rsp_valid !== 1'b1) $display("FAIL %s rsp_valid got=%b exp=1", tag, rsp_valid);
      else n_pass++;
      n_checks++;
      if (rsp_rdata !== exp_r) $display("FAIL %s rsp_rdata got=%h exp=%h", tag, rsp_rdata, exp_r);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b0) $display("FAIL %s ready_in_resp got=%b exp=0", tag, req_ready);
      else n_pass++;
      n_checks++;
      if ({mem_wr_en, mem_rd_en, mem_addr, mem_dat_in} !== 18'h0)
         $display("FAIL %s mem_idle_in_resp got=%b%b %h %h exp=00 00 00", tag,
                  mem_wr_en, mem_rd_en, mem_addr, mem_dat_in);
      else n_pass++;
      req_valid = 1'b0;
      @(posedge clk); #1;

      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL %s rsp_not_single got=%b exp=0", tag, rsp_valid);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s ready_after got=%b exp=1", tag, req_ready);
      else n_pass++;

      if (is_st) begin
         ref_mem[addr] = wd[7:0];
         if (op[1]) ref_mem[a1] = wd[15:8];
      end
   endtask

   task automatic test_reset();
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset req_ready got=%b exp=1", req_ready);
      else n_pass++;
      n_checks++;
      if (rsp_valid !== 1'b0) $display("FAIL reset rsp_valid got=%b exp=0", rsp_valid);
      else n_pass++;
      n_checks++;
      if (rsp_rdata !== 16'h0) $display("FAIL reset rsp_rdata got=%h exp=0000", rsp_rdata);
      else n_pass++;
      n_checks++;
      if ({mem_wr_en, mem_rd_en, mem_addr, mem_dat_in} !== 18'h0)
         $display("FAIL reset mem_port got=%b%b %h %h exp=00 00 00", mem_wr_en, mem_rd_en, mem_addr, mem_dat_in);
      else n_pass++;
   endtask

   task automatic test_byte();
      do_req(2'b01, 8'h10, 16'h00A5, 1'b0, "sb_10");
      do_req(2'b00, 8'h10, 16'h0000, 1'b0, "lb_10");
   endtask

   task automatic test_pair();
      do_req(2'b11, 8'h20, 16'hBEEF, 1'b0, "sh_20");
      do_req(2'b10, 8'h20, 16'h0000, 1'b0, "lh_20");
      do_req(2'b00, 8'h21, 16'h0000, 1'b0, "lb_21");
   endtask

   task automatic test_wrap();
      do_req(2'b11, 8'hFF, 16'h1234, 1'b0, "sh_ff");
      do_req(2'b10, 8'hFF, 16'h0000, 1'b0, "lh_ff");
      do_req(2'b00, 8'h00, 16'h0000, 1'b0, "lb_00");
   endtask

   task automatic test_busy_ignore();
      do_req(2'b11, 8'h30, 16'hCAFE, 1'b1, "busy_sh");
      do_req(2'b00, 8'h31, 16'hFFFF, 1'b1, "busy_lb");
      do_req(2'b10, 8'h30, 16'h0000, 1'b1, "busy_lh");
      repeat (3) begin
         n_checks++;
         if (rsp_valid !== 1'b0) $display("FAIL busy extra_rsp got=%b exp=0", rsp_valid);
         else n_pass++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid();
      do_req(2'b01, 8'h41, 16'h0077, 1'b0, "pre_41");
      req_valid = 1'b1;
      req_op    = 2'b11;
      req_addr  = 8'h40;
      req_wdata = 16'h5566;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (mem_wr_en !== 1'b1 || mem_addr !== 8'h41)
         $display("FAIL rstmid in_acc1 got=%b@%h exp=1@41", mem_wr_en, mem_addr);
      else n_pass++;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (mem_wr_en !== 1'b0) $display("FAIL rstmid wr_en_drop got=%b exp=0", mem_wr_en);
      else n_pass++;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL rstmid ready_in_reset got=%b exp=1", req_ready);
      else n_pass++;
      repeat (2) begin
         @(posedge clk); #1;
         n_checks++;
         if (rsp_valid !== 1'b0) $display("FAIL rstmid rsp_during_reset got=%b exp=0", rsp_valid);
         else n_pass++;
      end
      rst_n = 1'b1;
      n_checks++;
      if (mem[8'h40] !== 8'h66) $display("FAIL rstmid low_byte got=%h exp=66", mem[8'h40]);
      else n_pass++;
      n_checks++;
      if (mem[8'h41] !== 8'h77) $display("FAIL rstmid high_byte got=%h exp=77", mem[8'h41]);
      else n_pass++;
      @(posedge clk); #1;
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL rstmid after_release got=rsp%b rdy%b exp=rsp0 rdy1", rsp_valid, req_ready);
      else n_pass++;
      ref_mem[8'h40] = 8'h66;
      do_req(2'b10, 8'h40, 16'h0000, 1'b0, "lh_40");
   endtask

   task automatic test_random();
      logic [1:0]  op;
      logic [7:0]  addr;
      logic [15:0] wd;
      bit          junk;
      for (int i = 0; i < 80; i++) begin
         op   = 2'($urandom);
         addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(8'hF8 + 8'($urandom_range(0, 15)));
         wd   = 16'($urandom);
         junk = 1'($urandom);
         do_req(op, addr, wd, junk, "rand");
      end
   endtask

   initial begin
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_addr  = 8'h00;
      req_wdata = 16'h0000;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 8'($urandom);
         mem[i]    <= ref_mem[i];
      end
      #2;
      test_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_byte();
      test_pair();
      test_wrap();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
